clk_user_rst_seq: RTL and testbench

Power-up and recovery sequencer for the user clock wizard (two output clocks, active-high reset, locked status).
- Runs on the free-running input clock; drives the wizard reset and waits for lock, with timeout and bounded retry.
- Once lock has been stable, releases per-domain resets in staggered order.
- On lock loss, re-asserts all domain resets and re-runs the sequence.

---
 rtl/clk_user_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 19 +
 rtl/clk_user_rst_seq.sv | 99 +++++++++
 tb/tb_clk_user_rst_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_user_pkg.sv
// clk_user_pkg: shared FSM encoding and sizing helpers for the user clock reset sequencer
package clk_user_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    RST       = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;
  // smallest width able to count up to the longest phase
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  // first flop may go metastable, second gives it a full cycle to settle
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/clk_user_rst_seq.sv
// clk_user_rst_seq: wizard reset, lock qualification with retry, and staggered domain reset release
module clk_user_rst_seq
  import clk_user_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int NUM_DOMAINS    = 2,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                             clk_in1,
  input  logic                             resetn,
  input  logic                             restart,
  input  logic                             mmcm_locked,
  output logic                             mmcm_reset,
  output logic [NUM_DOMAINS-1:0]           domain_rst,
  output logic                             ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [STATE_W-1:0]               state
);
  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, NUM_DOMAINS * STAGGER_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'((NUM_DOMAINS - 1) * STAGGER_CYCLES);
  logic                   locked_s;
  state_e                 state_q, state_d, fail_state;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d, retry_inc;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d, rel_hit;
  logic                   mmcm_q, ready_q, fault_q;
  sync_2ff u_lock_sync (
    .clk_i  (clk_in1),
    .rst_ni (resetn),
    .d_i    (mmcm_locked),
    .q_o    (locked_s)
  );
  // next-state, shared counter and per-domain release decisions; restart overrides everything
  always_comb begin
    retry_inc  = retry_q + 1'b1;
    fail_state = int'(retry_inc) < MAX_RETRY ? RST : FAULT;
    state_d    = state_q;
    retry_d    = retry_q;
    if (restart) begin
      state_d = RST;
      retry_d = '0;
    end else begin
      case (state_q)
        RST:       state_d = cnt_q == RST_LAST ? WAIT_LOCK : RST;
        WAIT_LOCK: if (locked_s) state_d = STABLE;
                   else if (cnt_q == TO_LAST) begin
                     state_d = fail_state;
                     retry_d = retry_inc;
                   end
        STABLE:    if (!locked_s) begin
                     state_d = fail_state;
                     retry_d = retry_inc;
                   end else if (cnt_q == ST_LAST) state_d = RELEASE;
        RELEASE,
        RUN:       if (!locked_s) begin
                     state_d = RST;
                     retry_d = '0;
                   end else if (state_q == RELEASE && cnt_q == REL_LAST) state_d = RUN;
        default:   state_d = FAULT;
      endcase
    end
    cnt_d = (restart || state_d != state_q || state_q == RUN || state_q == FAULT) ? '0 : cnt_q + 1'b1;
    for (int i = 0; i < NUM_DOMAINS; i++) rel_hit[i] = cnt_d == CW'(i * STAGGER_CYCLES);
    dom_d = state_d == RUN ? '0 : state_d == RELEASE ? dom_q & ~rel_hit : '1;
  end
  // all outputs registered from the next state so they change together with the FSM
  always_ff @(posedge clk_in1 or negedge resetn)
    if (!resetn) begin
      state_q <= RST;
      cnt_q   <= '0;
      retry_q <= '0;
      dom_q   <= '1;
      mmcm_q  <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      dom_q   <= dom_d;
      mmcm_q  <= state_d inside {RST, FAULT};
      ready_q <= state_d == RUN;
      fault_q <= state_d == FAULT;
    end
  assign mmcm_reset = mmcm_q;
  assign domain_rst = dom_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;
endmodule

// File: tb/tb_clk_user_rst_seq.sv
// tb_clk_user_rst_seq: scenario tasks against timing expectations derived from the sequencer rules
module tb_clk_user_rst_seq;
  localparam int RC = 16, LT = 64, SC = 128, MR = 3, ND = 2, SG = 8;
  logic          clk_in1 = 1'b0, resetn = 1'b0, restart = 1'b0, mmcm_locked = 1'b0;
  logic          mmcm_reset, ready, fault;
  logic [ND-1:0] domain_rst;
  logic [1:0]    retry_cnt;
  logic [2:0]    state;
  int pass_cnt = 0, total_cnt = 0, inv_bad = 0;

  clk_user_rst_seq #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRY(MR), .NUM_DOMAINS(ND), .STAGGER_CYCLES(SG)
  ) dut (
    .clk_in1(clk_in1), .resetn(resetn), .restart(restart), .mmcm_locked(mmcm_locked),
    .mmcm_reset(mmcm_reset), .domain_rst(domain_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk_in1 = ~clk_in1;

  always @(negedge clk_in1)
    if (resetn && ready && (domain_rst != '0 || mmcm_reset || fault)) inv_bad++;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // spec-level latency: lock seen after 2 sync cycles, stable window, stagger gaps, one output cycle
  function automatic int exp_ready_lat(int d);
    return d + 2 + SC + (ND - 1) * SG + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in1);
  endtask

  task automatic count_mmcm(input logic lvl, output int n);
    n = 0;
    while (mmcm_reset === lvl && n < 10000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; restart = 1'b0; mmcm_locked = 1'b0;
    tick(3);
    total_cnt++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else pass_cnt++;
    total_cnt++; if (mmcm_reset !== 1'b1) $display("FAIL rst_mmcm got %b exp 1", mmcm_reset); else pass_cnt++;
    total_cnt++; if (domain_rst !== 2'b11) $display("FAIL rst_dom got %b exp 11", domain_rst); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", ready); else pass_cnt++;
    total_cnt++; if (fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", fault); else pass_cnt++;
    total_cnt++; if (retry_cnt !== 2'd0) $display("FAIL rst_retry got %0d exp 0", retry_cnt); else pass_cnt++;
  endtask

  task automatic test_powerup;
    int n, d, t0, t1, lat;
    d = $urandom_range(20, LT - 10);
    resetn = 1'b1;
    count_mmcm(1'b1, n);
    total_cnt++; if (n != RC) $display("FAIL pwr_rst_len got %0d exp %0d", n, RC); else pass_cnt++;
    tick(d);
    mmcm_locked = 1'b1;
    n = d; t0 = -1; t1 = -1;
    while (ready !== 1'b1 && n < d + SC + 200) begin
      tick(1);
      n++;
      if (t0 < 0 && domain_rst[0] === 1'b0) t0 = n;
      if (t1 < 0 && domain_rst[1] === 1'b0) t1 = n;
    end
    lat = exp_ready_lat(d);
    total_cnt++; if (ready !== 1'b1 || n < lat - 1 || n > lat + 1) $display("FAIL pwr_ready_lat got %0d (ready=%b) exp %0d+-1", n, ready, lat); else pass_cnt++;
    total_cnt++; if (t1 - t0 != SG) $display("FAIL pwr_stagger got %0d exp %0d", t1 - t0, SG); else pass_cnt++;
    total_cnt++; if (state !== 3'd4 || retry_cnt !== 2'd0 || mmcm_reset !== 1'b0) $display("FAIL pwr_run got state=%0d retry=%0d mmcm=%b exp 4/0/0", state, retry_cnt, mmcm_reset); else pass_cnt++;
  endtask

  task automatic test_timeout;
    int n;
    mmcm_locked = 1'b0; restart = 1'b1;
    tick(1);
    restart = 1'b0;
    for (int a = 1; a <= MR; a++) begin
      count_mmcm(1'b1, n);
      total_cnt++; if (n != RC) $display("FAIL to_rst_len[%0d] got %0d exp %0d", a, n, RC); else pass_cnt++;
      count_mmcm(1'b0, n);
      total_cnt++; if (n != LT) $display("FAIL to_wait_len[%0d] got %0d exp %0d", a, n, LT); else pass_cnt++;
      total_cnt++; if (retry_cnt !== 2'(a)) $display("FAIL to_retry[%0d] got %0d exp %0d", a, retry_cnt, a); else pass_cnt++;
    end
    total_cnt++; if (fault !== 1'b1 || state !== 3'd5 || mmcm_reset !== 1'b1 || domain_rst !== 2'b11 || ready !== 1'b0) $display("FAIL to_fault got f=%b s=%0d m=%b d=%b r=%b exp 1/5/1/11/0", fault, state, mmcm_reset, domain_rst, ready); else pass_cnt++;
    tick($urandom_range(20, 60));
    total_cnt++; if (fault !== 1'b1 || state !== 3'd5) $display("FAIL to_fault_sticky got f=%b s=%0d exp 1/5", fault, state); else pass_cnt++;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    total_cnt++; if (fault !== 1'b0 || retry_cnt !== 2'd0 || state !== 3'd0 || mmcm_reset !== 1'b1) $display("FAIL to_restart got f=%b r=%0d s=%0d m=%b exp 0/0/0/1", fault, retry_cnt, state, mmcm_reset); else pass_cnt++;
  endtask

  task automatic test_lock_at_timeout;
    int n;
    count_mmcm(1'b1, n);
    total_cnt++; if (n != RC) $display("FAIL bnd_rst_len got %0d exp %0d", n, RC); else pass_cnt++;
    tick(LT - 3);
    mmcm_locked = 1'b1;
    tick(3);
    total_cnt++; if (state !== 3'd2 || retry_cnt !== 2'd0) $display("FAIL bnd_lock_wins got s=%0d r=%0d exp 2/0", state, retry_cnt); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int n;
    tick($urandom_range(10, SC - 20));
    mmcm_locked = 1'b0;
    n = 0;
    while (mmcm_reset !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    total_cnt++; if (n != 3) $display("FAIL gl_latency got %0d exp 3", n); else pass_cnt++;
    total_cnt++; if (retry_cnt !== 2'd1 || state !== 3'd0) $display("FAIL gl_retry got r=%0d s=%0d exp 1/0", retry_cnt, state); else pass_cnt++;
    if (n < 5) tick(5 - n);
    mmcm_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < RC + SC + 100) begin
      tick(1);
      n++;
    end
    total_cnt++; if (ready !== 1'b1 || retry_cnt !== 2'd1) $display("FAIL gl_ready got rdy=%b r=%0d exp 1/1", ready, retry_cnt); else pass_cnt++;
  endtask

  task automatic test_lock_loss;
    int n, bad;
    bad = 0;
    for (int i = 0; i < $urandom_range(5, 30); i++) begin
      tick(1);
      if (ready !== 1'b1) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL ll_run_hold got %0d drops exp 0", bad); else pass_cnt++;
    mmcm_locked = 1'b0;
    n = 0;
    while (!(ready === 1'b0 && domain_rst === 2'b11) && n < 10) begin
      tick(1);
      n++;
    end
    total_cnt++; if (n < 1 || n > 3) $display("FAIL ll_latency got %0d exp 1..3", n); else pass_cnt++;
    total_cnt++; if (retry_cnt !== 2'd0 || state !== 3'd0 || mmcm_reset !== 1'b1) $display("FAIL ll_state got r=%0d s=%0d m=%b exp 0/0/1", retry_cnt, state, mmcm_reset); else pass_cnt++;
    count_mmcm(1'b1, n);
    tick($urandom_range(1, LT - 10));
    mmcm_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < LT + SC + 100) begin
      tick(1);
      n++;
    end
    total_cnt++; if (ready !== 1'b1 || retry_cnt !== 2'd0) $display("FAIL ll_rerun got rdy=%b r=%0d exp 1/0", ready, retry_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int n;
    mmcm_locked = 1'b0;
    n = 0;
    while (state !== 3'd0 && n < 10) begin
      tick(1);
      n++;
    end
    count_mmcm(1'b1, n);
    tick($urandom_range(1, 20));
    mmcm_locked = 1'b1;
    n = 0;
    while (domain_rst !== 2'b10 && n < LT + SC + 100) begin
      tick(1);
      n++;
    end
    total_cnt++; if (domain_rst !== 2'b10 || state !== 3'd3) $display("FAIL ar_release got d=%b s=%0d exp 10/3", domain_rst, state); else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++; if (domain_rst !== 2'b11 || mmcm_reset !== 1'b1 || state !== 3'd0 || ready !== 1'b0) $display("FAIL ar_immediate got d=%b m=%b s=%0d r=%b exp 11/1/0/0", domain_rst, mmcm_reset, state, ready); else pass_cnt++;
    mmcm_locked = 1'b0;
    tick(3);
  endtask

  task automatic test_restart_at_timeout;
    int n;
    resetn = 1'b1;
    for (int a = 1; a < MR; a++) begin
      count_mmcm(1'b1, n);
      count_mmcm(1'b0, n);
      total_cnt++; if (retry_cnt !== 2'(a) || n != LT) $display("FAIL rt_attempt[%0d] got r=%0d len=%0d exp %0d/%0d", a, retry_cnt, n, a, LT); else pass_cnt++;
    end
    count_mmcm(1'b1, n);
    tick(LT - 1);
    total_cnt++; if (state !== 3'd1 || retry_cnt !== 2'(MR - 1)) $display("FAIL rt_last_wait got s=%0d r=%0d exp 1/%0d", state, retry_cnt, MR - 1); else pass_cnt++;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    total_cnt++; if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 2'd0 || mmcm_reset !== 1'b1) $display("FAIL rt_restart_wins got s=%0d f=%b r=%0d m=%b exp 0/0/0/1", state, fault, retry_cnt, mmcm_reset); else pass_cnt++;
    tick(20);
    total_cnt++; if (fault !== 1'b0) $display("FAIL rt_no_fault got %b exp 0", fault); else pass_cnt++;
  endtask

  initial begin
    tick(1);
    test_reset;
    test_powerup;
    test_timeout;
    test_lock_at_timeout;
    test_glitch;
    test_lock_loss;
    test_async_reset;
    test_restart_at_timeout;
    total_cnt++; if (inv_bad != 0) $display("FAIL ready_invariant got %0d violations exp 0", inv_bad); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
